// File: rtl/auc_mmulinit_tbl_if.sv
// ---------------------------------------------------------------------------
// auc_mmulinit_tbl_if
// Bundle of every signal between the table-driven RAM initialiser and its
// surroundings: controller handshake (init_en/busy/done/err), constant and
// scalar tables, ALU pass-through request/response, and the RAM read/write
// port.
//   master : the initialiser itself (drives busy/done/err, ALU request and
//            RAM port; consumes tables, start request and ALU response)
//   slave  : the environment (top controller, ALU, RAM muxes)
// scl_a keeps at least one slot so the bus stays legal when NSCL = 0.
// ---------------------------------------------------------------------------
interface auc_mmulinit_tbl_if #(
    parameter int WID   = 256,
    parameter int AWID  = 5,
    parameter int OPWID = 4,
    parameter int NENT  = 8,
    parameter int NSCL  = 1
) ();
    localparam int SCN = (NSCL > 0) ? NSCL : 1;

    logic                   init_en;
    logic [NENT*WID-1:0]    tbl_wd;
    logic [NENT*AWID-1:0]   tbl_wa;
    logic [NENT-1:0]        tbl_msk;
    logic [SCN*AWID-1:0]    scl_a;
    logic                   init_busy;
    logic                   init_done;
    logic                   init_err;
    logic [OPWID-1:0]       init_opcode;
    logic                   init_carry;
    logic                   init_auen;
    logic                   init_auvld;
    logic [WID-1:0]         init_audat;
    logic [AWID-1:0]        init_ra;
    logic [AWID-1:0]        init_wa;
    logic                   init_we;
    logic [WID-1:0]         init_wd;

    modport master (
        input  init_en, tbl_wd, tbl_wa, tbl_msk, scl_a, init_auvld, init_audat,
        output init_busy, init_done, init_err, init_opcode, init_carry,
               init_auen, init_ra, init_wa, init_we, init_wd
    );

    modport slave (
        output init_en, tbl_wd, tbl_wa, tbl_msk, scl_a, init_auvld, init_audat,
        input  init_busy, init_done, init_err, init_opcode, init_carry,
               init_auen, init_ra, init_wa, init_we, init_wd
    );
endinterface

// File: rtl/auc_mmulinit_tbl.sv
// ---------------------------------------------------------------------------
// auc_mmulinit_tbl
// Table-driven RAM initialiser for the Montgomery-ladder scalar-mult core.
// On a start request it writes NENT constants (each individually maskable)
// into the operand RAM, then for each of NSCL scalars: reads it through the
// ALU pass-through, clamps it, and writes it back to the same address.
// A missing ALU response within TMO cycles aborts the sequence with an error.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; aborts any sequence without done
//   bus  : auc_mmulinit_tbl_if.master (handshake, tables, ALU, RAM port)
// All outputs are registered; init_opcode/init_carry are constants.
// ---------------------------------------------------------------------------
module auc_mmulinit_tbl #(
    parameter int              WID    = 256,
    parameter int              AWID   = 5,
    parameter int              OPWID  = 4,
    parameter int              NENT   = 8,
    parameter int              NSCL   = 1,
    parameter int              CLRLSB = 3,
    parameter int              TOPBIT = 254,
    parameter int              TMO    = 64,
    parameter logic [OPWID-1:0] OPC   = OPWID'(4'b0100)
) (
    input  logic                clk,
    input  logic                rst,
    auc_mmulinit_tbl_if.master  bus
);
    localparam int SCN = (NSCL > 0) ? NSCL : 1;
    localparam int CIW = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int SCW = (SCN > 1) ? $clog2(SCN) : 1;
    localparam int TCW = $clog2(TMO + 1);

    localparam logic [CIW-1:0] CI_LAST = CIW'(NENT - 1);
    localparam logic [SCW-1:0] SI_LAST = SCW'(SCN - 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TMO - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONST = 3'd1,
        ST_SRD   = 3'd2,
        ST_SWAIT = 3'd3,
        ST_SWR   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t             state_r;
    logic [CIW-1:0]     ci_r;
    logic [SCW-1:0]     si_r;
    logic [TCW-1:0]     tc_r;
    logic               err_flag_r;
    logic [WID-1:0]     scl_val_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               auen_r;
    logic [AWID-1:0]    ra_r;
    logic [AWID-1:0]    wa_r;
    logic               we_r;
    logic [WID-1:0]     wd_r;

    // Scalar clamp: clear the low CLRLSB bits, force TOPBIT high, clear
    // everything above TOPBIT, pass all other bits through.
    function automatic logic [WID-1:0] clamp_f(input logic [WID-1:0] x);
        logic [WID-1:0] r;
        r = '0;
        for (int b = 0; b < WID; b++) begin
            if (b < CLRLSB || b > TOPBIT) begin
                r[b] = 1'b0;
            end else if (b == TOPBIT) begin
                r[b] = 1'b1;
            end else begin
                r[b] = x[b];
            end
        end
        return r;
    endfunction

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ci_r       <= '0;
            si_r       <= '0;
            tc_r       <= '0;
            err_flag_r <= 1'b0;
            scl_val_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            auen_r     <= 1'b0;
            ra_r       <= '0;
            wa_r       <= '0;
            we_r       <= 1'b0;
            wd_r       <= '0;
        end else begin
            // Pulse-type outputs drop back every cycle unless a state re-asserts them.
            we_r   <= 1'b0;
            auen_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            ra_r   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.init_en) begin
                        ci_r    <= '0;
                        si_r    <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CONST;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CONST: begin
                    // Masked-out entries leave the write address/data untouched.
                    we_r <= bus.tbl_msk[ci_r];
                    if (bus.tbl_msk[ci_r]) begin
                        wa_r <= bus.tbl_wa[ci_r*AWID +: AWID];
                        wd_r <= bus.tbl_wd[ci_r*WID +: WID];
                    end else begin
                        wa_r <= wa_r;
                        wd_r <= wd_r;
                    end
                    if (ci_r == CI_LAST) begin
                        state_r <= (NSCL > 0) ? ST_SRD : ST_FIN;
                    end else begin
                        ci_r <= ci_r + 1'b1;
                    end
                end
                ST_SRD: begin
                    // Read address and ALU enable become visible together.
                    ra_r    <= bus.scl_a[si_r*AWID +: AWID];
                    auen_r  <= 1'b1;
                    tc_r    <= '0;
                    state_r <= ST_SWAIT;
                end
                ST_SWAIT: begin
                    if (bus.init_auvld) begin
                        scl_val_r <= clamp_f(bus.init_audat);
                        state_r   <= ST_SWR;
                    end else if (tc_r == TC_LAST) begin
                        err_flag_r <= 1'b1;
                        state_r    <= ST_FIN;
                    end else begin
                        tc_r <= tc_r + 1'b1;
                    end
                end
                ST_SWR: begin
                    we_r <= 1'b1;
                    wa_r <= bus.scl_a[si_r*AWID +: AWID];
                    wd_r <= scl_val_r;
                    if (si_r == SI_LAST) begin
                        state_r <= ST_FIN;
                    end else begin
                        si_r    <= si_r + 1'b1;
                        state_r <= ST_SRD;
                    end
                end
                ST_FIN: begin
                    done_r     <= 1'b1;
                    err_r      <= err_flag_r;
                    err_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.init_busy   = busy_r;
    assign bus.init_done   = done_r;
    assign bus.init_err    = err_r;
    assign bus.init_opcode = OPC;
    assign bus.init_carry  = 1'b0;
    assign bus.init_auen   = auen_r;
    assign bus.init_ra     = ra_r;
    assign bus.init_wa     = wa_r;
    assign bus.init_we     = we_r;
    assign bus.init_wd     = wd_r;
endmodule

// File: tb/tb_auc_mmulinit_tbl.sv
`timescale 1ns/1ps
module tb_auc_mmulinit_tbl;
    localparam int WID    = 256;
    localparam int AWID   = 5;
    localparam int OPWID  = 4;
    localparam int NENT   = 4;
    localparam int NSCL   = 2;
    localparam int CLRLSB = 3;
    localparam int TOPBIT = 254;
    localparam int TMO    = 64;
    localparam logic [OPWID-1:0] OPC = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    auc_mmulinit_tbl_if #(.WID(WID), .AWID(AWID), .OPWID(OPWID), .NENT(NENT), .NSCL(NSCL)) bus ();

    auc_mmulinit_tbl #(
        .WID(WID), .AWID(AWID), .OPWID(OPWID), .NENT(NENT), .NSCL(NSCL),
        .CLRLSB(CLRLSB), .TOPBIT(TOPBIT), .TMO(TMO), .OPC(OPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { int cyc; logic [AWID-1:0] addr; logic [WID-1:0] data; } wr_t;
    typedef struct { int cyc; logic err; } dn_t;
    typedef struct { int cyc; logic [AWID-1:0] ra; } rd_t;

    wr_t            wr_q[$];
    dn_t            dn_q[$];
    rd_t            rd_q[$];
    int             lat_q[$];
    logic [WID-1:0] dat_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    // current run description (latency -1 = ALU never answers)
    logic [NENT-1:0] cur_msk;
    logic [AWID-1:0] cur_wa [NENT];
    logic [WID-1:0]  cur_wd [NENT];
    logic [AWID-1:0] cur_sa [NSCL];
    int              cur_lat [NSCL];
    logic [WID-1:0]  cur_dat [NSCL];

    task automatic chk(input string nm, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WID-1:0] rnd_w();
        logic [WID-1:0] r;
        r = '0;
        for (int i = 0; i < WID/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference clamp built from bit masks.
    function automatic logic [WID-1:0] clamp_ref(input logic [WID-1:0] x);
        logic [WID-1:0] one;
        logic [WID-1:0] keep;
        one  = 1;
        keep = ((one << (TOPBIT + 1)) - one) & ~((one << CLRLSB) - one);
        return (x & keep) | (one << TOPBIT);
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ALU model: answers each auen after the queued latency; idles with noise
    initial begin
        int pend_cnt;
        bit pend;
        logic [WID-1:0] pdat;
        rd_t r;
        pend = 1'b0; pend_cnt = 0; pdat = '0;
        bus.init_auvld = 1'b0;
        bus.init_audat = '0;
        forever begin
            @(posedge clk); #1;
            bus.init_auvld = 1'b0;
            bus.init_audat = rnd_w();
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.init_auen) begin
                    if (rd_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexp_auen: got auen at cycle %0d, expected none", cyc);
                    end else begin
                        r = rd_q.pop_front();
                        chk_i("auen_cyc", cyc, r.cyc);
                        chk("init_ra", WID'(bus.init_ra), WID'(r.ra));
                    end
                    if (lat_q.size() > 0) begin
                        pend_cnt = lat_q.pop_front();
                        pdat = dat_q.pop_front();
                        pend = (pend_cnt >= 0);
                    end
                end
                if (pend) begin
                    if (pend_cnt == 0) begin
                        bus.init_auvld = 1'b1;
                        bus.init_audat = pdat;
                        pend = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end else if (!bus.init_busy && $urandom_range(0, 3) == 0) begin
                    bus.init_auvld = 1'b1;   // stray valid while idle must be ignored
                end
            end
        end
    end

    // monitor: compares every RAM write and done pulse against the scoreboard
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.init_we) begin
                    if (wr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexp_write: got write addr %0d at cycle %0d, expected none", bus.init_wa, cyc);
                    end else begin
                        w = wr_q.pop_front();
                        chk_i("wr_cyc", cyc, w.cyc);
                        chk("wr_addr", WID'(bus.init_wa), WID'(w.addr));
                        chk("wr_data", bus.init_wd, w.data);
                    end
                end
                if (bus.init_done) begin
                    done_cnt++;
                    if (dn_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexp_done: got done at cycle %0d, expected none", cyc);
                    end else begin
                        d = dn_q.pop_front();
                        chk_i("done_cyc", cyc, d.cyc);
                        chk("done_err", WID'(bus.init_err), WID'(d.err));
                        chk("busy_at_done", WID'(bus.init_busy), WID'(1'b0));
                        chk("opcode", WID'(bus.init_opcode), WID'(OPC));
                    end
                end
            end
        end
    end

    // Build the scoreboard for the current run and pulse init_en for one cycle.
    task automatic start_run();
        int  p;
        int  dcyc;
        logic err;
        for (int i = 0; i < NENT; i++) begin
            bus.tbl_wa[i*AWID +: AWID] = cur_wa[i];
            bus.tbl_wd[i*WID +: WID]   = cur_wd[i];
        end
        for (int s = 0; s < NSCL; s++) bus.scl_a[s*AWID +: AWID] = cur_sa[s];
        bus.tbl_msk = cur_msk;
        @(posedge clk); #1;
        bus.init_en = 1'b1;
        lat_q.delete(); dat_q.delete(); rd_q.delete();
        for (int i = 0; i < NENT; i++) begin
            if (cur_msk[i]) wr_q.push_back('{cyc: cyc + 2 + i, addr: cur_wa[i], data: cur_wd[i]});
        end
        p = cyc + NENT + 1;          // cycle of the first scalar read
        err = 1'b0;
        dcyc = 0;
        for (int s = 0; s < NSCL; s++) begin
            rd_q.push_back('{cyc: p + 1, ra: cur_sa[s]});
            lat_q.push_back(cur_lat[s]);
            dat_q.push_back(cur_dat[s]);
            if (cur_lat[s] < 0) begin
                err = 1'b1;
                dcyc = p + TMO + 2;
                break;
            end
            wr_q.push_back('{cyc: p + 3 + cur_lat[s], addr: cur_sa[s], data: clamp_ref(cur_dat[s])});
            p = p + 3 + cur_lat[s];
        end
        if (!err) dcyc = p + 1;
        dn_q.push_back('{cyc: dcyc, err: err});
        last_done_cyc = dcyc;
        @(posedge clk); #1;
        bus.init_en = 1'b0;
        chk("busy_run", WID'(bus.init_busy), WID'(1'b1));
    endtask

    // Wait (bounded) for exactly one done; optionally hammer init_en while busy.
    task automatic wait_done(input bit pulse_en);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (pulse_en && cyc < last_done_cyc) bus.init_en = 1'($urandom_range(0, 1));
            else bus.init_en = 1'b0;
        end
        bus.init_en = 1'b0;
        chk_i("done_seen", done_cnt - start, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_i("extra_done", done_cnt - start, 1);
    endtask

    // Reset part-way through a run: outputs clear, no done follows.
    task automatic mid_reset(input int delay);
        int start;
        repeat (delay) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_q.delete(); dn_q.delete(); rd_q.delete(); lat_q.delete(); dat_q.delete();
        start = done_cnt;
        @(negedge clk);
        chk("mr_we", WID'(bus.init_we), WID'(1'b0));
        chk("mr_wa", WID'(bus.init_wa), WID'(1'b0));
        chk("mr_wd", bus.init_wd, '0);
        chk("mr_auen", WID'(bus.init_auen), WID'(1'b0));
        chk("mr_busy", WID'(bus.init_busy), WID'(1'b0));
        chk("mr_done", WID'(bus.init_done), WID'(1'b0));
        repeat (TMO + 10) @(posedge clk);
        #1;
        chk_i("mr_no_done", done_cnt - start, 0);
    endtask

    task automatic set_directed(input logic [NENT-1:0] msk);
        cur_msk = msk;
        for (int i = 0; i < NENT; i++) begin
            cur_wa[i] = AWID'(i);
            cur_wd[i] = WID'((i + 1) * 10);
        end
        cur_sa[0] = AWID'(11);
        cur_sa[1] = AWID'(12);
        cur_lat[0] = 0;
        cur_dat[0] = '1;
        cur_lat[1] = 2;
        cur_dat[1] = WID'(5);
    endtask

    task automatic set_random();
        cur_msk = NENT'($urandom);
        for (int i = 0; i < NENT; i++) begin
            cur_wa[i] = AWID'($urandom);
            cur_wd[i] = rnd_w();
        end
        for (int s = 0; s < NSCL; s++) begin
            cur_sa[s]  = AWID'($urandom);
            cur_dat[s] = rnd_w();
            cur_lat[s] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
        end
    endtask

    initial begin
        bus.init_en = 1'b0;
        bus.tbl_wd  = '0;
        bus.tbl_wa  = '0;
        bus.tbl_msk = '0;
        bus.scl_a   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", WID'(bus.init_we), WID'(1'b0));
        chk("rst_wa", WID'(bus.init_wa), WID'(1'b0));
        chk("rst_wd", bus.init_wd, '0);
        chk("rst_ra", WID'(bus.init_ra), WID'(1'b0));
        chk("rst_auen", WID'(bus.init_auen), WID'(1'b0));
        chk("rst_done", WID'(bus.init_done), WID'(1'b0));
        chk("rst_err", WID'(bus.init_err), WID'(1'b0));
        chk("rst_busy", WID'(bus.init_busy), WID'(1'b0));
        chk("rst_carry", WID'(bus.init_carry), WID'(1'b0));
        chk("rst_opcode", WID'(bus.init_opcode), WID'(OPC));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // all entries written, both scalars clamped (all-ones and 0x5)
        set_directed(4'b1111);
        start_run();
        wait_done(1'b0);

        // sparse mask: only addresses 0 and 2, same done timing
        set_directed(4'b0101);
        start_run();
        wait_done(1'b0);

        // ALU timeout on first scalar
        set_directed(4'b1111);
        cur_lat[0] = -1;
        start_run();
        wait_done(1'b0);

        // ALU timeout on second scalar, first scalar still written
        set_directed(4'b0011);
        cur_lat[1] = -1;
        start_run();
        wait_done(1'b0);

        // start requests hammered while busy
        set_random();
        start_run();
        wait_done(1'b1);

        // reset in CONST, then in SWAIT, then a full fresh run
        set_directed(4'b1111);
        start_run();
        mid_reset(1);
        set_directed(4'b1111);
        cur_lat[0] = -1;
        start_run();
        mid_reset(NENT + 3);
        set_directed(4'b1111);
        start_run();
        wait_done(1'b0);

        // randomized runs
        for (int k = 0; k < 20; k++) begin
            set_random();
            start_run();
            wait_done(k[0]);
        end

        chk_i("wr_q_empty", wr_q.size(), 0);
        chk_i("dn_q_empty", dn_q.size(), 0);
        chk_i("rd_q_empty", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
